// File: rtl/ps2_host_tx_if.sv
// Bundle of the ps2_host_tx request handshake, pad sense lines and open-drain enables.
// The slave modport is the transmitter side; master is the surrounding logic and pads.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;

    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, done, err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request, 10-bit frame, ACK wait.
// Define PS2_TX_ACK_EN to turn a high ACK bit into err; otherwise the 11th fall always gives done.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 12000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input logic          clk,
    input logic          rstn,
    ps2_host_tx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_REQ,
        S_SHIFT,
        S_ACK
    } state_t;

    localparam int MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic fall;
    logic ack_ok;

    // Bus idles high, so the synchronizer resets to 1 to avoid a phantom fall.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_meta_q <= bus.ps2_clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_ACK_EN
    logic data_meta_q, data_sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= bus.ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign ack_ok = ~data_sync_q;
`else
    assign ack_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every next-state signal gets a default first, so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    frame_d  = {1'b1, ~^bus.tx_data, bus.tx_data};
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_ONE;
                if (fall) begin
                    data_oe_d = ~frame_q[0];
                    bitcnt_d  = 4'd1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (fall) begin
                    data_oe_d = ~frame_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CNT_ONE;
                if (fall) begin
                    done_d    = ack_ok;
                    err_d     = ~ack_ok;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                    bitcnt_d  = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout aborts the transfer, except that the ACK-state fall takes precedence.
        if ((state_q == S_REQ || state_q == S_SHIFT || state_q == S_ACK) &&
            cnt_q == TMO_LAST && !(state_q == S_ACK && fall)) begin
            done_d    = 1'b0;
            err_d     = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            cnt_d     = '0;
            bitcnt_d  = '0;
            state_d   = S_IDLE;
        end
    end

    assign bus.tx_ready    = (state_q == S_IDLE);
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain device model clocks frames out of the DUT
// (time-scaled device clock) and every check is an immediate assertion.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic clk      = 1'b0;
    logic rstn     = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int err_seen  = 0;

    logic [9:0] bits;
    int         to_cnt;

    ps2_host_tx_if bus ();

    assign bus.ps2_clk_i  = dev_clk  & ~bus.ps2_clk_oe;
    assign bus.ps2_data_i = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.done === 1'b1) done_seen++;
        if (bus.err === 1'b1) err_seen++;
    endtask

    task automatic clear_counts();
        done_seen = 0;
        err_seen  = 0;
    endtask

    // Request one byte and follow the inhibit/start phase until the clock is released.
    task automatic send(input logic [7:0] b, input bit timing);
        int hi;
        int both;
        int guard;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        if (timing) begin
            check("accept_clk_oe", bus.ps2_clk_oe, 1);
            check("accept_not_ready", bus.tx_ready, 0);
        end
        hi = 0;
        both = 0;
        guard = 0;
        while (bus.ps2_clk_oe === 1'b1 && guard < 5000) begin
            hi++;
            if (bus.ps2_data_oe === 1'b1) both++;
            tick();
            guard++;
        end
        if (timing) begin
            check("inhibit_len", hi, INH + 1);
            check("start_overlap", both, 1);
        end
        check("req_state", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b01);
    endtask

    // Device clocks 11 falls, samples each frame bit just before its rising edge,
    // and drives ack_bit during the 11th clock. abort_fall > 0 asserts reset mid-frame.
    task automatic dev_run(input logic ack_bit, input int abort_fall, input bit lat_chk,
                           input bit busy_inj, output logic [9:0] got);
        got = '0;
        repeat (5) tick();
        for (int f = 1; f <= 11; f++) begin
            if (f == 11) dev_data = ack_bit;
            dev_clk = 1'b0;
            for (int h = 0; h < HALF; h++) begin
                tick();
                if (lat_chk && f == 1 && h == 1) check("fall_to_oe_hold", bus.ps2_data_oe, 1);
                if (lat_chk && f == 1 && h == 2) check("fall_to_oe_3cyc", bus.ps2_data_oe, 0);
                if (lat_chk && f == 11 && h == 1) check("ack_no_early_pulse", bus.done | bus.err, 0);
                if (lat_chk && f == 11 && h == 2) begin
                    check("ack_done_3cyc", bus.done, 1);
                    check("ack_ready_back", bus.tx_ready, 1);
                end
                if (busy_inj && f == 3 && h == 4) begin
                    check("busy_not_ready", bus.tx_ready, 0);
                    bus.tx_data  = 8'hAA;
                    bus.tx_valid = 1'b1;
                end
                if (busy_inj && f == 3 && h == 5) bus.tx_valid = 1'b0;
                if (f == abort_fall && h == 5) begin
                    rstn = 1'b0;
                    #1;
                    check("rst_async_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
                    dev_clk  = 1'b1;
                    dev_data = 1'b1;
                    return;
                end
            end
            if (f <= 10) got[f-1] = bus.ps2_data_i;
            dev_clk = 1'b1;
            repeat (HALF) tick();
            if (f == 11) dev_data = 1'b1;
        end
        repeat (5) tick();
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_clk_oe", bus.ps2_clk_oe, 0);
        check("rst_data_oe", bus.ps2_data_oe, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_ready", bus.tx_ready, 1);
        rstn = 1'b1;
        repeat (3) tick();

        // 0xED "set LEDs": data 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK 0
        clear_counts();
        send(8'hED, 1'b1);
        dev_run(1'b0, 0, 1'b1, 1'b0, bits);
        check("frame_ED", bits, 10'h3ED);
        check("ED_done_once", done_seen, 1);
        check("ED_no_err", err_seen, 0);
        check("ED_ready", bus.tx_ready, 1);

        // Back-to-back parity corner cases
        clear_counts();
        send(8'h00, 1'b0);
        dev_run(1'b0, 0, 1'b0, 1'b0, bits);
        check("frame_00", bits, 10'h300);
        check("00_done_once", done_seen, 1);
        clear_counts();
        send(8'hFF, 1'b0);
        dev_run(1'b0, 0, 1'b0, 1'b0, bits);
        check("frame_FF", bits, 10'h3FF);
        check("FF_done_once", done_seen, 1);
        clear_counts();
        send(8'h01, 1'b0);
        dev_run(1'b0, 0, 1'b0, 1'b0, bits);
        check("frame_01", bits, 10'h201);
        check("01_done_once", done_seen, 1);

        // No device clock: err exactly TMO cycles after entering REQ
        clear_counts();
        send(8'h5A, 1'b0);
        to_cnt = 0;
        while (bus.err !== 1'b1 && to_cnt < 3 * TMO) begin
            tick();
            to_cnt++;
        end
        check("timeout_cycles", to_cnt, TMO);
        check("timeout_oe_released", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        repeat (5) tick();
        check("timeout_err_once", err_seen, 1);
        check("timeout_no_done", done_seen, 0);
        check("timeout_ready", bus.tx_ready, 1);

        // Device leaves data high on the 11th clock
        clear_counts();
        send(8'h3C, 1'b0);
        dev_run(1'b1, 0, 1'b0, 1'b0, bits);
        check("frame_3C", bits, 10'h33C);
`ifdef PS2_TX_ACK_EN
        check("nack_err", err_seen, 1);
        check("nack_no_done", done_seen, 0);
`else
        check("nack_done", done_seen, 1);
        check("nack_no_err", err_seen, 0);
`endif

        // Reset after the 4th fall, then a clean 0xF3
        clear_counts();
        send(8'h12, 1'b0);
        dev_run(1'b0, 4, 1'b0, 1'b0, bits);
        repeat (3) tick();
        check("rst_hold_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
        rstn = 1'b1;
        repeat (5) tick();
        check("rst_no_done", done_seen, 0);
        check("rst_no_err", err_seen, 0);
        check("rst_ready_after", bus.tx_ready, 1);
        clear_counts();
        send(8'hF3, 1'b0);
        dev_run(1'b0, 0, 1'b0, 1'b0, bits);
        check("frame_F3", bits, 10'h3F3);
        check("F3_done_once", done_seen, 1);
        check("F3_no_err", err_seen, 0);

        // tx_valid with 0xAA while busy must not disturb 0x96
        clear_counts();
        send(8'h96, 1'b0);
        dev_run(1'b0, 0, 1'b0, 1'b1, bits);
        check("frame_96_busy", bits, 10'h396);
        check("busy_done_once", done_seen, 1);
        repeat (10) tick();
        check("busy_no_restart", bus.ps2_clk_oe, 0);
        check("busy_ready", bus.tx_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
